// File: rtl/clint_rtc_gen.sv
// Fractional-N RTC reference for the CLINT rtc_i input: a phase accumulator
// whose carry toggles rtc_o, with a one-deep, phase-coherent increment update.
module clint_rtc_gen #(
   parameter int unsigned        ACC_WIDTH   = 32,
   parameter logic [ACC_WIDTH:0] DEFAULT_INC = {1'b1, {ACC_WIDTH{1'b0}}}
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic                 en_i,
   input  logic                 halt_i,
   input  logic                 cfg_valid_i,
   output logic                 cfg_ready_o,
   input  logic [ACC_WIDTH:0]   cfg_inc_i,
   output logic                 rtc_o,
   output logic                 tick_o,
   output logic [ACC_WIDTH:0]   active_inc_o
);

   localparam int unsigned       INC_W   = ACC_WIDTH + 1;
   localparam logic [INC_W-1:0]  INC_MAX = {1'b1, {ACC_WIDTH{1'b0}}};

   logic [ACC_WIDTH-1:0] acc_q;
   logic [INC_W-1:0]     pend_inc_q;
   logic [INC_W-1:0]     sum_c;
   logic [INC_W-1:0]     sat_inc_c;
   logic                 adv_c;
   logic                 carry_c;
   logic                 accept_c;
   logic                 apply_c;
   logic                 pending_c;

   // The config slot is full exactly when ready is low, so one flop serves both.
   assign pending_c = ~cfg_ready_o;
   assign adv_c     = en_i & ~halt_i;
   assign sum_c     = {1'b0, acc_q} + active_inc_o;
   assign carry_c   = adv_c & sum_c[ACC_WIDTH];
   assign accept_c  = cfg_valid_i & cfg_ready_o;
   assign sat_inc_c = (cfg_inc_i > INC_MAX) ? INC_MAX : cfg_inc_i;

   // Swap on a carry keeps phase; swap at once when stopped so a zero inc
   // or a frozen accumulator cannot strand the pending value.
   assign apply_c = pending_c & (carry_c | (active_inc_o == '0) | ~adv_c);

   // Phase accumulator and square-wave output.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         acc_q  <= '0;
         rtc_o  <= 1'b0;
         tick_o <= 1'b0;
      end else begin
         if (adv_c) begin
            acc_q <= sum_c[ACC_WIDTH-1:0];
         end
         rtc_o  <= rtc_o ^ carry_c;
         tick_o <= carry_c & ~rtc_o;
      end
   end

   // Config slot and active increment.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cfg_ready_o  <= 1'b1;
         pend_inc_q   <= '0;
         active_inc_o <= DEFAULT_INC;
      end else begin
         if (accept_c) begin
            cfg_ready_o <= 1'b0;
            pend_inc_q  <= sat_inc_c;
         end else if (apply_c) begin
            cfg_ready_o  <= 1'b1;
            active_inc_o <= pend_inc_q;
         end
      end
   end

endmodule

// File: tb/tb_clint_rtc_gen.sv
// Directed bench for clint_rtc_gen (ACC_WIDTH=8): stimulus queues hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_clint_rtc_gen;

   logic       aclk = 1'b0;
   logic       aresetn = 1'b0;
   logic       en_i = 1'b0;
   logic       halt_i = 1'b0;
   logic       cfg_valid_i = 1'b0;
   logic       cfg_ready_o;
   logic [8:0] cfg_inc_i = '0;
   logic       rtc_o;
   logic       tick_o;
   logic [8:0] active_inc_o;

   clint_rtc_gen #(.ACC_WIDTH(8)) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .en_i         (en_i),
      .halt_i       (halt_i),
      .cfg_valid_i  (cfg_valid_i),
      .cfg_ready_o  (cfg_ready_o),
      .cfg_inc_i    (cfg_inc_i),
      .rtc_o        (rtc_o),
      .tick_o       (tick_o),
      .active_inc_o (active_inc_o)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      int         cyc;
      string      name;
      logic       rtc;
      logic       tick;
      logic       rdy;
      logic [8:0] inc;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   scyc    = 0;
   int   mcyc    = 0;

   task automatic expect_at(input int c, input string nm, input logic r,
                            input logic t, input logic y, input logic [8:0] i);
      exp_t e;
      e.cyc = c; e.name = nm; e.rtc = r; e.tick = t; e.rdy = y; e.inc = i;
      q.push_back(e);
   endtask

   task automatic wait_to(input int n);
      while (scyc < n) begin
         @(negedge aclk);
         scyc++;
      end
   endtask

   // Monitor: outputs are stable at the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge aclk);
         mcyc++;
         while (q.size() > 0 && q[0].cyc <= mcyc) begin
            e = q.pop_front();
            n_tests++;
            if (e.cyc < mcyc) begin
               n_fail++;
               $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, mcyc);
            end else if ({rtc_o, tick_o, cfg_ready_o, active_inc_o} !== {e.rtc, e.tick, e.rdy, e.inc}) begin
               n_fail++;
               $display("FAIL %s @%0d: got rtc=%b tick=%b rdy=%b inc=%0d, want rtc=%b tick=%b rdy=%b inc=%0d",
                        e.name, mcyc, rtc_o, tick_o, cfg_ready_o, active_inc_o,
                        e.rtc, e.tick, e.rdy, e.inc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d expectations pending", q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset, then divide-by-two with the default increment
      expect_at(1, "rst", 0, 0, 1, 256);
      expect_at(2, "rst", 0, 0, 1, 256);
      expect_at(3, "t1",  0, 0, 1, 256);
      expect_at(4, "t1",  1, 1, 1, 256);
      expect_at(5, "t1",  0, 0, 1, 256);
      expect_at(6, "t1",  1, 1, 1, 256);
      expect_at(7, "t1",  0, 0, 1, 256);
      wait_to(3);
      aresetn = 1'b1;
      en_i    = 1'b1;

      // 2: switch to inc=64 while running
      wait_to(7);
      cfg_valid_i = 1'b1; cfg_inc_i = 9'd64;
      expect_at(8,  "t2_pend",  1, 1, 0, 256);
      expect_at(9,  "t2_apply", 0, 0, 1, 64);
      expect_at(12, "t2",       0, 0, 1, 64);
      expect_at(13, "t2_rise",  1, 1, 1, 64);
      expect_at(16, "t2",       1, 0, 1, 64);
      expect_at(17, "t2_fall",  0, 0, 1, 64);
      expect_at(20, "t2",       0, 0, 1, 64);
      expect_at(21, "t2_rise",  1, 1, 1, 64);
      wait_to(8);
      cfg_valid_i = 1'b0;

      // 3: oversize increment saturates, waits for the next carry
      wait_to(21);
      cfg_valid_i = 1'b1; cfg_inc_i = 9'd300;
      expect_at(22, "t3_pend",  1, 0, 0, 64);
      expect_at(24, "t3_pend",  1, 0, 0, 64);
      expect_at(25, "t3_sat",   0, 0, 1, 256);
      expect_at(26, "t3",       1, 1, 1, 256);
      expect_at(27, "t3",       0, 0, 1, 256);
      wait_to(22);
      cfg_valid_i = 1'b0;

      // 4: inc=96 with a 10-cycle halt; carry phase preserved
      wait_to(27);
      cfg_valid_i = 1'b1; cfg_inc_i = 9'd96;
      expect_at(28, "t4_pend",  1, 1, 0, 256);
      expect_at(29, "t4_apply", 0, 0, 1, 96);
      expect_at(31, "t4",       0, 0, 1, 96);
      expect_at(32, "t4_rise",  1, 1, 1, 96);
      expect_at(33, "t4",       1, 0, 1, 96);
      expect_at(38, "t4_halt",  1, 0, 1, 96);
      expect_at(43, "t4_halt",  1, 0, 1, 96);
      expect_at(44, "t4_resume",1, 0, 1, 96);
      expect_at(45, "t4_fall",  0, 0, 1, 96);
      expect_at(46, "t4",       0, 0, 1, 96);
      expect_at(47, "t4_rise",  1, 1, 1, 96);
      wait_to(28);
      cfg_valid_i = 1'b0;
      wait_to(33);
      halt_i = 1'b1;
      wait_to(43);
      halt_i = 1'b0;

      // 5: inc=0 freezes; the next offer applies at once
      wait_to(47);
      cfg_valid_i = 1'b1; cfg_inc_i = 9'd0;
      expect_at(48, "t5_pend",  1, 0, 0, 96);
      expect_at(49, "t5_pend",  1, 0, 0, 96);
      expect_at(50, "t5_zero",  0, 0, 1, 0);
      expect_at(51, "t5_frozen",0, 0, 1, 0);
      wait_to(48);
      cfg_valid_i = 1'b0;
      wait_to(51);
      cfg_valid_i = 1'b1; cfg_inc_i = 9'd128;
      expect_at(52, "t5_pend",  0, 0, 0, 0);
      expect_at(53, "t5_apply", 0, 0, 1, 128);
      expect_at(54, "t5",       0, 0, 1, 128);
      expect_at(55, "t5_rise",  1, 1, 1, 128);
      expect_at(56, "t5",       1, 0, 1, 128);
      expect_at(57, "t5_fall",  0, 0, 1, 128);
      expect_at(58, "t5",       0, 0, 1, 128);
      wait_to(52);
      cfg_valid_i = 1'b0;

      // 6: reset mid-period with a value pending
      wait_to(58);
      cfg_valid_i = 1'b1; cfg_inc_i = 9'd64;
      expect_at(59, "t6_pend",  1, 1, 0, 128);
      wait_to(59);
      cfg_valid_i = 1'b0;
      #2;
      aresetn = 1'b0;
      en_i    = 1'b0;
      expect_at(60, "t6_rst",   0, 0, 1, 256);
      expect_at(61, "t6_rst",   0, 0, 1, 256);
      wait_to(61);
      aresetn = 1'b1;
      en_i    = 1'b1;
      expect_at(62, "t6_lost",  1, 1, 1, 256);
      expect_at(63, "t6",       0, 0, 1, 256);
      expect_at(64, "t6",       1, 1, 1, 256);

      wait_to(66);
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         n_tests++;
         n_fail++;
         $display("FAIL %s: expectation for cycle %0d never checked", e.name, e.cyc);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
